// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 scancode constants, prefix FSM states and the make-code to ASCII mapping.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_A        = 8'h41;
  localparam logic [7:0] ASCII_0        = 8'h30;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } key_map_t;

  // Translate a make code into a character; valid=0 for anything unmapped.
  function automatic key_map_t map_key(input logic [7:0] code, input logic upper,
                                       input logic ctrl_en);
    key_map_t   m;
    logic [4:0] idx;
    logic [3:0] dig;
    logic       is_letter;
    logic       is_digit;
    m         = '0;
    idx       = '0;
    dig       = '0;
    is_letter = 1'b1;
    is_digit  = 1'b1;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    case (code)
      8'h70: dig = 4'd0;  8'h69: dig = 4'd1;  8'h72: dig = 4'd2;  8'h7A: dig = 4'd3;
      8'h6B: dig = 4'd4;  8'h73: dig = 4'd5;  8'h74: dig = 4'd6;  8'h6C: dig = 4'd7;
      8'h75: dig = 4'd8;  8'h7D: dig = 4'd9;
      default: is_digit = 1'b0;
    endcase
    if (is_letter) begin
      m.valid = 1'b1;
      m.ch    = ASCII_A + 8'(idx) + (upper ? 8'h00 : ASCII_CASE_OFS);
    end else if (is_digit) begin
      m.valid = 1'b1;
      m.ch    = ASCII_0 + 8'(dig);
    end else if (ctrl_en) begin
      case (code)
        SC_ENTER: begin m.valid = 1'b1; m.ch = ASCII_CR;    end
        SC_SPACE: begin m.valid = 1'b1; m.ch = ASCII_SPACE; end
        SC_BKSP:  begin m.valid = 1'b1; m.ch = ASCII_BS;    end
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO with count-based full/empty and a sticky overflow flag.
module key_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      rd_en_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_do_rd;
  logic              w_do_wr;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_do_rd = rd_en_i && !w_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign w_do_wr = wr_en_i && (!w_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en_i && w_full && !rd_en_i) r_ovf <= 1'b1;
    end
  end

  assign rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/key_decoder_fifo.sv
// PS/2 set-2 scancode decoder: prefix FSM, shift/caps tracking and ASCII mapping into a key FIFO.
module key_decoder_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          CASE_AWARE = 1'b1,
  parameter bit          CTRL_KEYS  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   code_i,
  input  logic                         code_valid_i,
  input  logic                         rd_en_i,
  output logic [7:0]                   ascii_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         overflow_o,
  output logic                         shift_o,
  output logic                         caps_o
);

  kbd_state_e r_state;
  kbd_state_e w_state_nxt;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;
  logic       r_caps_held;
  logic       w_make;
  logic       w_release;
  logic       w_upper;
  logic       w_push;
  key_map_t   w_map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Prefix tracking; only plain makes and plain releases reach the decoder.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_release   = 1'b0;
    if (code_valid_i) begin
      case (r_state)
        ST_IDLE: begin
          if (code_i == SC_BREAK)     w_state_nxt = ST_BRK;
          else if (code_i == SC_EXT)  w_state_nxt = ST_EXT;
          else                        w_make      = 1'b1;
        end
        ST_BRK: begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT:  w_state_nxt = (code_i == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // caps_held blocks typematic repeats of caps lock from toggling again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else begin
      if (w_make) begin
        if (code_i == SC_LSHIFT) r_lshift <= 1'b1;
        if (code_i == SC_RSHIFT) r_rshift <= 1'b1;
        if (code_i == SC_CAPS) begin
          if (!r_caps_held) r_caps <= ~r_caps;
          r_caps_held <= 1'b1;
        end
      end
      if (w_release) begin
        if (code_i == SC_LSHIFT) r_lshift    <= 1'b0;
        if (code_i == SC_RSHIFT) r_rshift    <= 1'b0;
        if (code_i == SC_CAPS)   r_caps_held <= 1'b0;
      end
    end
  end

  assign shift_o = r_lshift | r_rshift;
  assign caps_o  = r_caps;
  assign w_upper = !CASE_AWARE || (shift_o ^ r_caps);
  assign w_map   = map_key(code_i, w_upper, CTRL_KEYS);
  assign w_push  = w_make && w_map.valid;

  key_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (w_push),
    .wr_data_i  (w_map.ch),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (ascii_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

endmodule

// File: tb/tb_key_decoder_fifo.sv
// Self-checking bench for key_decoder_fifo: directed scenarios plus random bytes against a queue model.
module tb_key_decoder_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] code_i = 8'h00;
  logic       code_valid_i = 1'b0;
  logic       rd_en_i = 1'b0;
  logic [7:0] ascii_o;
  logic       empty_o;
  logic       full_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       shift_o;
  logic       caps_o;

  int n_checks = 0;
  int n_fail   = 0;

  key_decoder_fifo #(
    .FIFO_DEPTH (DEPTH),
    .CASE_AWARE (1'b1),
    .CTRL_KEYS  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .rd_en_i      (rd_en_i),
    .ascii_o      (ascii_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .shift_o      (shift_o),
    .caps_o       (caps_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_q[$];
  logic       m_ovf, m_ls, m_rs, m_caps, m_held, m_ext, m_brk;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75,
                                8'h7D};
  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h70, 8'h69, 8'h7D, 8'h12, 8'h59, 8'h58,
                            8'hF0, 8'hE0, 8'h5A, 8'h29, 8'h66, 8'h0E};

  function automatic int m_map(input logic [7:0] c, input logic upper);
    for (int i = 0; i < 26; i++)
      if (c == letter_sc[i]) return upper ? (8'h41 + i) : (8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (c == digit_sc[i]) return 8'h30 + i;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h29) return 8'h20;
    if (c == 8'h66) return 8'h08;
    return -1;
  endfunction

  function automatic logic [7:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_apply(input logic v, input logic [7:0] c, input logic rd);
    int   ch;
    logic do_pop;
    logic acc;
    ch  = -1;
    acc = 1'b0;
    if (v) begin
      if (!m_ext && !m_brk) begin
        if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else begin
          ch = m_map(c, (m_ls | m_rs) ^ m_caps);
          if (c == 8'h12) m_ls = 1;
          if (c == 8'h59) m_rs = 1;
          if (c == 8'h58) begin
            if (!m_held) m_caps = !m_caps;
            m_held = 1;
          end
        end
      end else if (m_brk && !m_ext) begin
        if (c == 8'h12) m_ls = 0;
        if (c == 8'h59) m_rs = 0;
        if (c == 8'h58) m_held = 0;
        m_brk = 0;
      end else if (m_ext && !m_brk) begin
        if (c == 8'hF0) m_brk = 1;
        else m_ext = 0;
      end else begin
        m_ext = 0;
        m_brk = 0;
      end
    end
    do_pop = rd && (m_q.size() > 0);
    if (ch >= 0) begin
      if (m_q.size() < DEPTH || do_pop) acc = 1'b1;
      else m_ovf = 1'b1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(8'(ch));
  endtask

  // One clock: drive at negedge, return at the next negedge with outputs settled.
  task automatic cyc(input logic v, input logic [7:0] c, input logic rd);
    code_valid_i = v;
    code_i       = c;
    rd_en_i      = rd;
    model_apply(v, c, rd);
    @(negedge clk);
    code_valid_i = 1'b0;
    rd_en_i      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ascii_o !== 8'h00) begin n_fail++; $display("FAIL rst_ascii: got %h expected 00", ascii_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty_o); end
    n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", full_o); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow_o); end
    n_checks++; if ({shift_o, caps_o} !== 2'b00) begin n_fail++; $display("FAIL rst_mods: got %b expected 00", {shift_o, caps_o}); end
  endtask

  task automatic test_make_break();
    cyc(1, 8'h1C, 0);
    n_checks++; if (ascii_o !== 8'h61 || empty_o !== 1'b0) begin n_fail++; $display("FAIL s1_latency: got %h/%b expected 61/0", ascii_o, empty_o); end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h1C, 0);
    n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL s1_release_nopush: got %0d expected 1", count_o); end
    cyc(1, 8'h1C, 0);
    n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL s1_back_idle: got %0d expected 2", count_o); end
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL s1_drain: got %b expected 1", empty_o); end
  endtask

  task automatic test_shift();
    cyc(1, 8'h12, 0);
    n_checks++; if (shift_o !== 1'b1) begin n_fail++; $display("FAIL s2_shift_on: got %b expected 1", shift_o); end
    cyc(1, 8'h1C, 0);
    n_checks++; if (ascii_o !== 8'h41) begin n_fail++; $display("FAIL s2_upper: got %h expected 41", ascii_o); end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h12, 0);
    n_checks++; if (shift_o !== 1'b0) begin n_fail++; $display("FAIL s2_shift_off: got %b expected 0", shift_o); end
    cyc(1, 8'h1C, 0);
    cyc(0, 8'h00, 1);
    n_checks++; if (ascii_o !== 8'h61 || count_o !== 3'd1) begin n_fail++; $display("FAIL s2_lower: got %h/%0d expected 61/1", ascii_o, count_o); end
    cyc(0, 8'h00, 1);
  endtask

  task automatic test_caps();
    cyc(1, 8'h58, 0);
    n_checks++; if (caps_o !== 1'b1) begin n_fail++; $display("FAIL s3_caps_on: got %b expected 1", caps_o); end
    cyc(1, 8'h58, 0);
    cyc(1, 8'h58, 0);
    n_checks++; if (caps_o !== 1'b1 || count_o !== 3'd0) begin n_fail++; $display("FAIL s3_repeat: got %b/%0d expected 1/0", caps_o, count_o); end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h58, 0);
    cyc(1, 8'h1C, 0);
    n_checks++; if (ascii_o !== 8'h41 || caps_o !== 1'b1) begin n_fail++; $display("FAIL s3_caps_letter: got %h/%b expected 41/1", ascii_o, caps_o); end
    cyc(0, 8'h00, 1);
    cyc(1, 8'h58, 0);
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h58, 0);
    n_checks++; if (caps_o !== 1'b0) begin n_fail++; $display("FAIL s3_caps_off: got %b expected 0", caps_o); end
  endtask

  task automatic test_extended();
    cyc(1, 8'hE0, 0);
    cyc(1, 8'h12, 0);
    n_checks++; if (shift_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL s4_ext_shift: got %b/%0d expected 0/0", shift_o, count_o); end
    cyc(1, 8'h1C, 0);
    n_checks++; if (ascii_o !== 8'h61 || count_o !== 3'd1) begin n_fail++; $display("FAIL s4_letter: got %h/%0d expected 61/1", ascii_o, count_o); end
    cyc(0, 8'h00, 1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) cyc(1, 8'h69, 0);
    n_checks++; if (count_o !== 3'd4 || full_o !== 1'b1 || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL s5_full: got cnt=%0d full=%b ovf=%b expected 4/1/1", count_o, full_o, overflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ascii_o !== 8'h31) begin n_fail++; $display("FAIL s5_pop%0d: got %h expected 31", i, ascii_o); end
      cyc(0, 8'h00, 1);
    end
    n_checks++; if (empty_o !== 1'b1 || ascii_o !== 8'h00) begin n_fail++; $display("FAIL s5_empty: got %b/%h expected 1/00", empty_o, ascii_o); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 8'h69, 0);
    cyc(1, 8'h72, 0);
    cyc(1, 8'hF0, 0);
    n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL s6_pre: got %0d expected 2", count_o); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (empty_o !== 1'b1 || count_o !== 3'd0 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL s6_async: got empty=%b cnt=%0d ovf=%b expected 1/0/0", empty_o, count_o, overflow_o);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cyc(1, 8'h1C, 0);
    n_checks++; if (ascii_o !== 8'h61 || count_o !== 3'd1) begin n_fail++; $display("FAIL s6_after: got %h/%0d expected 61/1", ascii_o, count_o); end
  endtask

  task automatic test_push_pop_full();
    cyc(0, 8'h00, 1);
    cyc(1, 8'h69, 0);
    cyc(1, 8'h72, 0);
    cyc(1, 8'h7A, 0);
    cyc(1, 8'h6B, 0);
    cyc(1, 8'h73, 1);
    n_checks++; if (count_o !== 3'd4 || full_o !== 1'b1 || overflow_o !== 1'b0 || ascii_o !== 8'h32) begin
      n_fail++; $display("FAIL pp_full: got cnt=%0d full=%b ovf=%b head=%h expected 4/1/0/32", count_o, full_o, overflow_o, ascii_o);
    end
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
    n_checks++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL pp_underflow: got %0d/%b expected 0/1", count_o, empty_o); end
    cyc(1, 8'h5A, 0);
    n_checks++; if (ascii_o !== 8'h0D || count_o !== 3'd1) begin n_fail++; $display("FAIL pp_after_empty_rd: got %h/%0d expected 0D/1", ascii_o, count_o); end
  endtask

  task automatic test_random();
    logic       v;
    logic       rd;
    logic [7:0] c;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      cyc(v, c, rd);
      n_checks++; if (ascii_o !== exp_head()) begin n_fail++; $display("FAIL rnd_ascii@%0d: got %h expected %h", n, ascii_o, exp_head()); end
      n_checks++; if (count_o !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, count_o, m_q.size()); end
      n_checks++; if (empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got e=%b f=%b expected size %0d", n, empty_o, full_o, m_q.size());
      end
      n_checks++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, overflow_o, m_ovf); end
      n_checks++; if (shift_o !== (m_ls | m_rs) || caps_o !== m_caps) begin
        n_fail++; $display("FAIL rnd_mods@%0d: got s=%b c=%b expected s=%b c=%b", n, shift_o, caps_o, m_ls | m_rs, m_caps);
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_push_pop_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_decoder_fifo.md
KEY_DECODER_FIFO -- requirements
Module: key_decoder_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets the number of buffered ASCII entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter CASE_AWARE, default 1: 1 means shift/caps-aware letter case; 0 means letters are always uppercase.
REQ-003 Parameter CTRL_KEYS, default 1: 1 means Enter, Space and Backspace are mapped; 0 means they are unmapped.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 code_i  input  8  received PS/2 scancode byte.
REQ-007 code_valid_i  input  1  one-cycle strobe qualifying code_i.
REQ-008 rd_en_i  input  1  pops the FIFO head.
REQ-009 ascii_o  output  8  FIFO head (first-word-fall-through); 8'h00 when empty.
REQ-010 empty_o  output  1  FIFO holds no entries.
REQ-011 full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 count_o  output  $clog2(FIFO_DEPTH)+1  number of entries held.
REQ-013 overflow_o  output  1  sticky flag: a character was dropped because the FIFO was full.
REQ-014 shift_o, caps_o  output  1 each  current shift state and caps-lock state.

Function
REQ-015 The prefix FSM SHALL have four states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); it SHALL advance only on code_valid_i.
REQ-016 FSM transitions on a byte:
- IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make and stays in IDLE.
- BRK: any byte is a release and returns to IDLE.
- EXT: F0 -> EXT_BRK; any other byte returns to IDLE with no push.
- EXT_BRK: any byte returns to IDLE with no push.
REQ-017 Left shift is 8'h12 and right shift is 8'h59; each SHALL be tracked as an independent held flag, set on make and cleared on release; shift_o SHALL be the OR of the two flags.
REQ-018 Extended make and extended release bytes SHALL never alter the shift, caps or caps_held state.
REQ-019 Caps lock (8'h58) make SHALL toggle caps_o only when caps_held is 0, and SHALL then set caps_held; a release of 8'h58 SHALL clear caps_held, so typematic repeats do not re-toggle.
REQ-020 Letter makes SHALL use the PS/2 set-2 letter table (A=1C ... Z=1A); the byte pushed SHALL be 8'h41..8'h5A when CASE_AWARE=0 or (shift_o XOR caps_o)=1, and otherwise that value plus 8'h20.
REQ-021 Keypad digit makes SHALL push 8'h30..8'h39 regardless of shift or caps (0=70, 1=69, 2=72, 3=7A, 4=6B, 5=73, 6=74, 7=6C, 8=75, 9=7D).
REQ-022 With CTRL_KEYS=1, make 5A SHALL push 8'h0D, make 29 SHALL push 8'h20 and make 66 SHALL push 8'h08.
REQ-023 A make of any unmapped code, any modifier key, or any byte received in BRK, EXT or EXT_BRK SHALL push nothing.
REQ-024 Each typematic repeat of a mapped make SHALL push one entry.
REQ-025 Latency: a mapped make strobed in cycle N SHALL be visible at ascii_o, with empty_o low, in cycle N+1 when the FIFO was empty.
REQ-026 rd_en_i SHALL remove the head entry at the clock edge; rd_en_i while empty SHALL be ignored, with no underflow and no pointer change.
REQ-027 A push while full without a simultaneous pop SHALL drop the character and set overflow_o, which SHALL remain set until reset.
REQ-028 A push and pop in the same cycle SHALL both take effect, including when the FIFO is full; count_o SHALL then be unchanged.
REQ-029 The read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by count, not by pointer equality alone.

Reset
REQ-030 Reset SHALL force FSM=IDLE, clear both shift flags, caps_o and caps_held, set count_o=0 and empty_o=1, clear full_o and overflow_o, and drive ascii_o=8'h00.
REQ-031 An assertion of reset mid-sequence, for example between F0 and the released code, SHALL discard the pending prefix and all buffered entries.

Structure
REQ-032 A shared package kbd_pkg SHALL hold the FSM state enum, the scancode constants (F0, E0, 12, 59, 58, 5A, 29, 66) and the ASCII constants.
REQ-033 Buffering SHALL be a sub-module key_fifo, parametrised by data width and depth; scancode mapping and the FSM SHALL reside in key_decoder_fifo.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Scenario 1: bytes 1C, F0, 1C -> one entry 8'h61, then no further push; the FSM ends in IDLE.
- Scenario 2: 12, 1C, F0, 12, 1C -> entries 8'h41 then 8'h61; shift_o reads 1 then 0.
- Scenario 3: 58, 58, 58, F0, 58, 1C -> caps_o=1 after the first 58, held through the repeats; then entry 8'h41.
- Scenario 4: E0, 12, 1C (no shift held) -> single entry 8'h61; shift_o stays 0.
- Scenario 5: FIFO_DEPTH=4; push 5 x 69 with no reads -> count_o=4, full_o=1, overflow_o=1; then four pops yield 8'h31 x4 and empty_o=1.
- Scenario 6: reset asserted after F0 with 2 entries buffered -> empty_o=1; the next byte 1C pushes 8'h61.
